// File: rtl/clcg_pkg.sv
// clcg_pkg: shared FSM encoding and slice width for the dual-CLCG serial comparator
package clcg_pkg;
  localparam int SLICE_W = 2;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/comp2b.sv
// comp2b: combinational 2-bit magnitude comparator slice (a_big: a>b, b_big: b>a)
module comp2b
  import clcg_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               a_big,
  output logic               b_big
);
  assign a_big = a > b;
  assign b_big = b > a;
endmodule

// File: rtl/serial_word_cmp.sv
// serial_word_cmp: MSB-first 2-bit-per-cycle magnitude compare of a/b; ready in IDLE, done pulse with held a_gt/b_gt/eq and slices_used
module serial_word_cmp
  import clcg_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             a_gt,
  output logic             b_gt,
  output logic             eq,
  output logic [CW:0]      slices_used
);
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic [CW:0] used;
  logic a_big, b_big, decided;
  comp2b u_slice (
    .a(sa[WIDTH-1 -: SLICE_W]),
    .b(sb[WIDTH-1 -: SLICE_W]),
    .a_big(a_big),
    .b_big(b_big)
  );
  assign decided = a_big | b_big | (cnt == '0);
  assign ready = (state != S_SCAN) && (state != S_DONE);
  assign done = state == S_DONE;
  always_comb begin
    state_nx = S_IDLE;
    if (state == S_SCAN) state_nx = decided ? S_DONE : S_SCAN;
    else if (ready) state_nx = start ? S_SCAN : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      used <= '0;
      a_gt <= 1'b0;
      b_gt <= 1'b0;
      eq <= 1'b0;
      slices_used <= '0;
    end else if (ready && start) begin
      sa <= a;
      sb <= b;
      cnt <= CW'(WIDTH / 2 - 1);
      used <= (CW + 1)'(1);
    end else if (state == S_SCAN) begin
      if (decided) begin
        a_gt <= a_big;
        b_gt <= b_big;
        eq <= ~(a_big | b_big);
        slices_used <= used;
      end else begin
        sa <= sa << SLICE_W;
        sb <= sb << SLICE_W;
        cnt <= cnt - CW'(1);
        used <= used + (CW + 1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_word_cmp.sv
// tb_serial_word_cmp: directed self-checking bench for serial_word_cmp at WIDTH=8
module tb_serial_word_cmp;
  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] a, b;
  logic ready, done, a_gt, b_gt, eq;
  logic [2:0] slices_used;
  int checks = 0;
  int passed = 0;
  serial_word_cmp #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .a_gt(a_gt), .b_gt(b_gt), .eq(eq),
    .slices_used(slices_used)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input int busy_cyc,
                        output int done_cyc, output int pulses, output bit ready_ok);
    done_cyc = -1;
    pulses = 0;
    ready_ok = 1'b1;
    a = av;
    b = bv;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      if (c == busy_cyc) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
      end
      if (done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc < 0 || c == done_cyc) begin
        if (ready !== 1'b0) ready_ok = 1'b0;
      end else if (c == done_cyc + 1) begin
        if (ready !== 1'b1) ready_ok = 1'b0;
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (a_gt !== 1'b0) $display("FAIL reset_a_gt got %b want 0", a_gt); else passed++;
    checks++; if (b_gt !== 1'b0) $display("FAIL reset_b_gt got %b want 0", b_gt); else passed++;
    checks++; if (eq !== 1'b0) $display("FAIL reset_eq got %b want 0", eq); else passed++;
    checks++; if (slices_used !== 3'd0) $display("FAIL reset_used got %0d want 0", slices_used); else passed++;
  endtask
  task automatic test_compare(input string nm, input logic [7:0] av, input logic [7:0] bv, input int busy_cyc,
                              input int exp_cyc, input logic ea, input logic eb, input logic ee, input logic [2:0] eu);
    int dc, np;
    bit rok;
    launch(av, bv, busy_cyc, dc, np, rok);
    checks++; if (dc != exp_cyc) $display("FAIL %s_done_cycle got %0d want %0d", nm, dc, exp_cyc); else passed++;
    checks++; if (np != 1) $display("FAIL %s_done_pulses got %0d want 1", nm, np); else passed++;
    checks++; if (!rok) $display("FAIL %s_ready_pattern got bad want low-through-done", nm); else passed++;
    checks++; if (a_gt !== ea) $display("FAIL %s_a_gt got %b want %b", nm, a_gt, ea); else passed++;
    checks++; if (b_gt !== eb) $display("FAIL %s_b_gt got %b want %b", nm, b_gt, eb); else passed++;
    checks++; if (eq !== ee) $display("FAIL %s_eq got %b want %b", nm, eq, ee); else passed++;
    checks++; if (slices_used !== eu) $display("FAIL %s_used got %0d want %0d", nm, slices_used, eu); else passed++;
  endtask
  task automatic test_reset_mid_scan();
    int np = 0;
    a = 8'h00;
    b = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (a_gt !== 1'b0 || b_gt !== 1'b0 || eq !== 1'b0) $display("FAIL midscan_results got %b%b%b want 000", a_gt, b_gt, eq); else passed++;
    checks++; if (slices_used !== 3'd0) $display("FAIL midscan_used got %0d want 0", slices_used); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL midscan_ready got %b want 1", ready); else passed++;
    for (int c = 0; c < 8; c++) begin
      if (done) np++;
      step();
    end
    checks++; if (np != 0) $display("FAIL midscan_done_pulses got %0d want 0", np); else passed++;
  endtask
  task automatic test_start_through_reset();
    int dc = -1;
    rst = 1'b1;
    start = 1'b1;
    a = 8'h80;
    b = 8'h40;
    step();
    step();
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      if (done && dc < 0) dc = c;
    end
    checks++; if (dc != 2) $display("FAIL held_start_done_cycle got %0d want 2", dc); else passed++;
    checks++; if (a_gt !== 1'b1 || b_gt !== 1'b0 || eq !== 1'b0) $display("FAIL held_start_result got %b%b%b want 100", a_gt, b_gt, eq); else passed++;
  endtask
  initial begin
    test_reset();
    test_compare("early", 8'hA5, 8'h25, -1, 2, 1'b1, 1'b0, 1'b0, 3'd1);
    test_compare("late", 8'h3C, 8'h3D, -1, 5, 1'b0, 1'b1, 1'b0, 3'd4);
    test_compare("equal", 8'h5A, 8'h5A, -1, 5, 1'b0, 1'b0, 1'b1, 3'd4);
    test_compare("slice1", 8'h10, 8'h20, -1, 3, 1'b0, 1'b1, 1'b0, 3'd2);
    test_compare("busy", 8'h3C, 8'h3D, 2, 5, 1'b0, 1'b1, 1'b0, 3'd4);
    test_compare("slice2", 8'h0C, 8'h08, -1, 4, 1'b1, 1'b0, 1'b0, 3'd3);
    test_reset_mid_scan();
    test_start_through_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
